avg_pool_window_core: RTL and testbench
=======================================

AVG_POOL_WINDOW_CORE -- requirements
Module: avg_pool_window_core

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- input_map_address_datawidth, 13, input BRAM address width
- output_map_address_datawidth, 11, output BRAM address width
- number_datawidth, 16, signed two's-complement sample width
- STATE_DATAWIDTH, 4, width of state
- AVG1_STATE / AVG2_STATE / AVG3_STATE, 3 / 6 / 9, layer state codes
- AVG1_INPUT_SIZE / AVG2_INPUT_SIZE / AVG3_INPUT_SIZE, 80 / 36 / 14, input map side N
- AVG1_OUTPUT_SIZE / AVG2_OUTPUT_SIZE / AVG3_OUTPUT_SIZE, 40 / 18 / 7, output map side M = N/2

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all logic on rising edge
- reset, input, 1, asynchronous, active-low reset
- enable, input, 1, run request from the multi-core pooling controller
- state, input, STATE_DATAWIDTH, selects layer geometry
- BRAM_Pool_In1, input, number_datawidth, input BRAM read data, valid one cycle after its address
- BRAM_Pool_In1_Address, output, input_map_address_datawidth, input BRAM read address
- BRAM_Pool_Out1, output, number_datawidth, pooled result
- BRAM_Pool_Out1_Address, output, output_map_address_datawidth, result write address
- wr_ena, output, 1, output BRAM write strobe, one cycle per result

Function
REQ-003 The block SHALL be active only when enable=1 and state equals one of AVG1/2/3_STATE; otherwise it is idle.
REQ-004 N and M SHALL be selected from state; while idle, N=AVG1_INPUT_SIZE is used.
REQ-005 Window (r,c), r,c in 0..M-1, SHALL be processed in raster order (c fastest).
REQ-006 Each window SHALL issue four consecutive read addresses, one per cycle: (2r)N+2c, (2r)N+2c+1, (2r+1)N+2c, (2r+1)N+2c+1.
REQ-007 Addresses SHALL advance every active cycle with no bubbles; one pass SHALL take exactly N*N cycles.
REQ-008 Address N*N-1 SHALL appear on BRAM_Pool_In1_Address for exactly one cycle per pass; the next active cycle SHALL present address 0 (automatic restart).
REQ-009 Read data SHALL be sampled one cycle after its address; the four samples SHALL be summed sign-extended in a number_datawidth+2 bit accumulator.
REQ-010 Result SHALL be sum arithmetic-shifted right by 2 (truncation toward minus infinity); it is then truncated to number_datawidth bits, which cannot overflow.
REQ-011 wr_ena SHALL pulse high for exactly one cycle, in the cycle after the fourth sample of a window is on BRAM_Pool_In1. This is 5 cycles after that window's first address cycle.
REQ-012 During the wr_ena pulse, BRAM_Pool_Out1 SHALL hold the result and BRAM_Pool_Out1_Address SHALL equal r*M+c.
REQ-013 Between pulses, data and address outputs SHALL hold their last values.
REQ-014 Each pass SHALL produce exactly M*M writes; the output address SHALL wrap from M*M-1 to 0.
REQ-015 On enable falling or state leaving the AVG states, the block SHALL clear the window, row and column counters and drop any partial window. From the next cycle, input address returns to 0 and wr_ena stays 0.
REQ-016 A write already scheduled for the cycle of deactivation SHALL be suppressed.
REQ-017 On a change of state between two AVG codes while enabled, the block SHALL restart at window (0,0) with the new geometry.

Reset
REQ-018 On reset=0 the following SHALL clear asynchronously to 0: BRAM_Pool_In1_Address, BRAM_Pool_Out1, BRAM_Pool_Out1_Address, wr_ena, accumulator, all counters.
REQ-019 After reset release, the first address SHALL be 0 on the first active cycle.
REQ-020 Reset asserted mid-pass SHALL abort the pass with no further write.

Verification
REQ-021 AVG3_STATE, enable=1, BRAM at addresses 0, 1, 14, 15 = 4, 8, 12, 16 -> addresses 0, 1, 14, 15 on consecutive cycles; wr_ena 5 cycles after the first address; Out1=10, Out1_Address=0.
REQ-022 Samples -1, -1, -1, -2 (0xFFFF, 0xFFFF, 0xFFFF, 0xFFFE) -> Out1=0xFFFE (-2); samples 0x7FFF x4 -> 0x7FFF.
REQ-023 AVG3 full pass -> 196 address cycles; address 195 exactly once, then 0; 49 wr_ena pulses with addresses 0..48 in order; second pass repeats identically.
REQ-024 AVG1 full pass -> 6400 cycles, 1600 writes, last Out1_Address=1599, address 6399 once; AVG2 -> 1296 cycles, 324 writes.
REQ-025 enable dropped after the 2nd read of a window, then re-raised -> no wr_ena for the partial window; restart at address 0 / output address 0.
REQ-026 reset pulsed low mid-pass -> all outputs 0 immediately (asynchronous); after release, sequence restarts from address 0.

Source files
------------

// File: rtl/avg_pool_window_core.sv
// 2x2 average-pooling window engine: streams four reads per window from the input map BRAM
// and writes one floor(sum/4) result per window to the output map BRAM.
module avg_pool_window_core #(
  parameter int input_map_address_datawidth  = 13,
  parameter int output_map_address_datawidth = 11,
  parameter int number_datawidth             = 16,
  parameter int STATE_DATAWIDTH              = 4,
  parameter int AVG1_STATE                   = 3,
  parameter int AVG2_STATE                   = 6,
  parameter int AVG3_STATE                   = 9,
  parameter int AVG1_INPUT_SIZE              = 80,
  parameter int AVG2_INPUT_SIZE              = 36,
  parameter int AVG3_INPUT_SIZE              = 14,
  parameter int AVG1_OUTPUT_SIZE             = 40,
  parameter int AVG2_OUTPUT_SIZE             = 18,
  parameter int AVG3_OUTPUT_SIZE             = 7
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [STATE_DATAWIDTH-1:0]              state,
  input  logic [number_datawidth-1:0]             BRAM_Pool_In1,
  output logic [input_map_address_datawidth-1:0]  BRAM_Pool_In1_Address,
  output logic [number_datawidth-1:0]             BRAM_Pool_Out1,
  output logic [output_map_address_datawidth-1:0] BRAM_Pool_Out1_Address,
  output logic                                    wr_ena
);

  localparam int AW = input_map_address_datawidth;
  localparam int OW = output_map_address_datawidth;
  localparam int DW = number_datawidth;
  localparam int SW = number_datawidth + 2;

  logic          valid_state, active, run;
  logic          active_reg, samp_valid_reg;
  logic [STATE_DATAWIDTH-1:0] state_reg;
  logic [AW-1:0] n_size, line_idx, col_off, addr_next;
  logic [OW-1:0] m_size, m_sq;
  logic [OW-1:0] col_reg, row_reg, col_next, row_next, wcount_reg;
  logic [1:0]    phase_reg, phase_next, samp_phase_reg;
  logic [SW-1:0] acc_reg, sample_ext, sum_next;

  always_comb begin
    valid_state = (state == STATE_DATAWIDTH'(AVG1_STATE)) ||
                  (state == STATE_DATAWIDTH'(AVG2_STATE)) ||
                  (state == STATE_DATAWIDTH'(AVG3_STATE));
    active = enable && valid_state;
    // A switch between two pooling layers while running costs one flush cycle, then restarts at (0,0).
    run = active && !(active_reg && (state != state_reg));

    n_size = AW'(AVG1_INPUT_SIZE);
    m_size = OW'(AVG1_OUTPUT_SIZE);
    if (state == STATE_DATAWIDTH'(AVG2_STATE)) begin
      n_size = AW'(AVG2_INPUT_SIZE);
      m_size = OW'(AVG2_OUTPUT_SIZE);
    end else if (state == STATE_DATAWIDTH'(AVG3_STATE)) begin
      n_size = AW'(AVG3_INPUT_SIZE);
      m_size = OW'(AVG3_OUTPUT_SIZE);
    end
    m_sq = m_size * m_size;
  end

  always_comb begin
    phase_next = phase_reg + 2'd1;
    col_next   = col_reg;
    row_next   = row_reg;
    if (phase_reg == 2'd3) begin
      if (col_reg == m_size - 1'b1) begin
        col_next = '0;
        row_next = (row_reg == m_size - 1'b1) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
    // Window (r,c) phase p reads row 2r+p[1], column 2c+p[0].
    line_idx  = AW'({row_next, 1'b0}) + AW'(phase_next[1]);
    col_off   = AW'({col_next, 1'b0}) + AW'(phase_next[0]);
    addr_next = line_idx * n_size + col_off;

    sample_ext = {{2{BRAM_Pool_In1[DW-1]}}, BRAM_Pool_In1};
    sum_next   = (samp_phase_reg == 2'd0) ? sample_ext : acc_reg + sample_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BRAM_Pool_In1_Address  <= '0;
      BRAM_Pool_Out1         <= '0;
      BRAM_Pool_Out1_Address <= '0;
      wr_ena                 <= 1'b0;
      acc_reg                <= '0;
      phase_reg              <= '0;
      col_reg                <= '0;
      row_reg                <= '0;
      wcount_reg             <= '0;
      samp_valid_reg         <= 1'b0;
      samp_phase_reg         <= '0;
      active_reg             <= 1'b0;
      state_reg              <= '0;
    end else begin
      active_reg <= active;
      state_reg  <= state;
      wr_ena     <= 1'b0;
      if (!run) begin
        BRAM_Pool_In1_Address <= '0;
        phase_reg             <= '0;
        col_reg               <= '0;
        row_reg               <= '0;
        wcount_reg            <= '0;
        samp_valid_reg        <= 1'b0;
        samp_phase_reg        <= '0;
      end else begin
        BRAM_Pool_In1_Address <= addr_next;
        phase_reg             <= phase_next;
        col_reg               <= col_next;
        row_reg               <= row_next;
        samp_valid_reg        <= 1'b1;
        samp_phase_reg        <= phase_reg;
        if (samp_valid_reg) begin
          acc_reg <= sum_next;
          if (samp_phase_reg == 2'd3) begin
            // Dropping the two LSBs is an arithmetic shift by 2; the top two bits are pure sign.
            BRAM_Pool_Out1         <= sum_next[DW+1:2];
            BRAM_Pool_Out1_Address <= wcount_reg;
            wr_ena                 <= 1'b1;
            wcount_reg             <= (wcount_reg == m_sq - 1'b1) ? '0 : wcount_reg + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_window_core.sv
// Directed bench for avg_pool_window_core: a registered-read BRAM model plus
// table-driven single-window vectors and full-pass / deactivation / reset sequences.
module tb_avg_pool_window_core;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  state;
  logic [15:0] in1;
  logic [12:0] in_addr;
  logic [15:0] out1;
  logic [10:0] out_addr;
  logic        wr_ena;
  logic [15:0] mem [0:8191];
  int          total = 0;
  int          bad = 0;

  avg_pool_window_core dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .state                  (state),
    .BRAM_Pool_In1          (in1),
    .BRAM_Pool_In1_Address  (in_addr),
    .BRAM_Pool_Out1         (out1),
    .BRAM_Pool_Out1_Address (out_addr),
    .wr_ena                 (wr_ena)
  );

  always #5 clk = ~clk;
  always @(posedge clk) in1 <= mem[in_addr];

  typedef struct {
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on the falling edge where address 0 of window (0,0) is first shown (AVG3 geometry).
  task automatic check_first(input string tag, input logic [15:0] exp);
    int exp_a [4];
    exp_a[0] = 0; exp_a[1] = 1; exp_a[2] = 14; exp_a[3] = 15;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4) check({tag, "_addr"}, 32'(in_addr), 32'(exp_a[k]));
      if (k < 5) check({tag, "_wr_idle"}, 32'(wr_ena), 32'd0);
      else begin
        check({tag, "_wr"}, 32'(wr_ena), 32'd1);
        check({tag, "_data"}, 32'(out1), 32'(exp));
        check({tag, "_oaddr"}, 32'(out_addr), 32'd0);
      end
    end
    $display("window %s: data=%h oaddr=%0d", tag, out1, out_addr);
  endtask

  task automatic start_window(input string tag, input logic [15:0] exp);
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    state  = 4'd9;
    enable = 1'b1;
    check_first(tag, exp);
  endtask

  task automatic run_pass(input string tag, input logic [3:0] st, input int n, input int m, input int npasses);
    int addr_err = 0, wr_err = 0, data_err = 0, oaddr_err = 0;
    int writes = 0, last_cnt = 0, last_oaddr = -1, after_last = -1;
    int cycles = npasses * n * n;
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    state  = st;
    enable = 1'b1;
    for (int k = 0; k <= cycles + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k < cycles) begin
        int j = k % (n * n);
        int w = j / 4;
        int p = j % 4;
        int ea = (2 * (w / m) + p / 2) * n + 2 * (w % m) + p % 2;
        if (in_addr !== 13'(ea)) addr_err++;
        if (in_addr == 13'(n * n - 1)) last_cnt++;
      end
      if (k == n * n) after_last = int'(in_addr);
      begin
        bit exp_wr = (k >= 5) && ((k - 5) % 4 == 0) && ((k - 5) / 4 < npasses * m * m);
        if (wr_ena !== exp_wr) wr_err++;
        if (exp_wr) begin
          int w = ((k - 5) / 4) % (m * m);
          int r = w / m;
          int c = w % m;
          int sum = 0;
          sum += int'($signed(mem[(2 * r) * n + 2 * c]));
          sum += int'($signed(mem[(2 * r) * n + 2 * c + 1]));
          sum += int'($signed(mem[(2 * r + 1) * n + 2 * c]));
          sum += int'($signed(mem[(2 * r + 1) * n + 2 * c + 1]));
          if (out1 !== 16'(sum >>> 2)) data_err++;
          if (out_addr !== 11'(w)) oaddr_err++;
          writes++;
          last_oaddr = int'(out_addr);
        end
      end
    end
    check({tag, "_addr_seq_errs"}, 32'(addr_err), 32'd0);
    check({tag, "_wr_timing_errs"}, 32'(wr_err), 32'd0);
    check({tag, "_data_errs"}, 32'(data_err), 32'd0);
    check({tag, "_oaddr_errs"}, 32'(oaddr_err), 32'd0);
    check({tag, "_writes"}, 32'(writes), 32'(npasses * m * m));
    check({tag, "_last_addr_count"}, 32'(last_cnt), 32'(npasses));
    check({tag, "_addr_after_last"}, 32'(after_last), 32'd0);
    check({tag, "_last_oaddr"}, 32'(last_oaddr), 32'(m * m - 1));
    $display("pass %s: writes=%0d last_oaddr=%0d addr_errs=%0d data_errs=%0d", tag, writes, last_oaddr, addr_err, data_err);
    enable = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'd4,    16'd8,    16'd12,   16'd16,   16'd10};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[5] = '{16'd1,    16'd1,    16'd1,    16'd0,    16'd0};
    vecs[6] = '{16'd5,    16'hFFFD, 16'd2,    16'd0,    16'd1};
    vecs[7] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF};

    for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 40503 + (i >> 2) * 7);
    reset  = 1'b0;
    enable = 1'b0;
    state  = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_in_addr", 32'(in_addr), 32'd0);
    check("reset_out1", 32'(out1), 32'd0);
    check("reset_oaddr", 32'(out_addr), 32'd0);
    check("reset_wr", 32'(wr_ena), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem[0]  = vecs[i].s0;
      mem[1]  = vecs[i].s1;
      mem[14] = vecs[i].s2;
      mem[15] = vecs[i].s3;
      start_window($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 40503 + (i >> 2) * 7);
    run_pass("avg3", 4'd9, 14, 7, 2);
    run_pass("avg2", 4'd6, 36, 18, 1);
    run_pass("avg1", 4'd3, 80, 40, 1);

    // Partial window abandoned by dropping enable after two reads.
    mem[0] = 16'd4; mem[1] = 16'd8; mem[14] = 16'd12; mem[15] = 16'd16;
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    state  = 4'd9;
    enable = 1'b1;
    check("drop_addr0", 32'(in_addr), 32'd0);
    @(negedge clk);
    check("drop_addr1", 32'(in_addr), 32'd1);
    @(negedge clk) enable = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("drop_idle_wr", 32'(wr_ena), 32'd0);
      check("drop_idle_addr", 32'(in_addr), 32'd0);
    end
    enable = 1'b1;
    check_first("reenable", 16'd10);

    // Layer switch AVG2 -> AVG3 while enabled.
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    state  = 4'd6;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    state = 4'd9;
    begin
      int n = 0;
      while (in_addr != 13'd0 && n < 4) begin
        check("switch_wr_idle", 32'(wr_ena), 32'd0);
        @(negedge clk);
        n++;
      end
      check("switch_restart_seen", 32'(in_addr), 32'd0);
    end
    check_first("switch", 16'd10);

    // Asynchronous reset mid-pass.
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    state  = 4'd9;
    enable = 1'b1;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_in_addr", 32'(in_addr), 32'd0);
    check("areset_out1", 32'(out1), 32'd0);
    check("areset_oaddr", 32'(out_addr), 32'd0);
    check("areset_wr", 32'(wr_ena), 32'd0);
    @(negedge clk);
    check("areset_hold_wr", 32'(wr_ena), 32'd0);
    reset = 1'b1;
    check_first("after_reset", 16'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
